// File: rtl/zone_max_accum_pkg.sv
// Shared backlight constants: zone geometry, lane width and band/frame sizing
// used by the zone-maximum accumulator and its per-lane registers.
package zone_max_accum_pkg;

  localparam int LANE_W             = 8;
  localparam int ZONES_DEF          = 24;
  localparam int LINES_PER_BAND_DEF = 135;
  localparam int BANDS_DEF          = 8;
  localparam int ZONE_PIX_W         = 80;
  localparam int ACTIVE_W           = 1920;
  localparam int BAND_IDX_W         = 3;
  localparam int LINE_CNT_W         = 8;

  typedef logic [LANE_W-1:0] laneT;

  function automatic laneT laneMax(input laneT a, input laneT b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zone_lane_max.sv
// One zone lane: running unsigned maximum of the pixels presented while
// enabled, with a synchronous clear that takes priority over the update.
module zone_lane_max
  import zone_max_accum_pkg::*;
(
  input  logic iODCK,
  input  logic iRst_n,
  input  logic iClr,
  input  logic iEn,
  input  laneT iPix,
  output laneT oMax
);

  always_ff @(posedge iODCK or negedge iRst_n) begin
    if (!iRst_n) begin
      oMax <= '0;
    end else if (iClr) begin
      oMax <= '0;
    end else if (iEn) begin
      oMax <= laneMax(oMax, iPix);
    end
  end

endmodule

// File: rtl/zone_max_accum.sv
// Per-band, per-zone peak luminance tracker for the backlight controller.
// Publishes the zone maxima once every LINES_PER_BAND active lines.
module zone_max_accum
  import zone_max_accum_pkg::*;
#(
  parameter int LINES_PER_BAND = LINES_PER_BAND_DEF,
  parameter int BANDS          = BANDS_DEF,
  parameter int ZONES          = ZONES_DEF
) (
  input  logic                       iODCK,
  input  logic                       iRst_n,
  input  logic                       iDE,
  input  logic                       iVS,
  input  logic [ZONES*LANE_W-1:0]    iPixelData,
  output logic [ZONES*LANE_W-1:0]    oZoneMax,
  output logic                       oZoneValid,
  output logic [BAND_IDX_W-1:0]      oBandIdx,
  output logic                       oFrameDone
);

  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(LINES_PER_BAND - 1);
  localparam logic [BAND_IDX_W-1:0] LAST_BAND = BAND_IDX_W'(BANDS - 1);

  logic [ZONES*LANE_W-1:0] pixD1;
  logic [ZONES*LANE_W-1:0] accBus;
  logic                    deD1;
  logic                    deD2;
  logic                    vsD1;
  logic                    vsD2;
  logic [LINE_CNT_W-1:0]   lineCnt;
  logic [BAND_IDX_W-1:0]   bandCnt;
  logic                    lineEnd;
  logic                    bandEnd;
  logic                    frameStart;
  logic                    publish;
  logic                    accClr;

  always_ff @(posedge iODCK or negedge iRst_n) begin
    if (!iRst_n) begin
      pixD1 <= '0;
      deD1  <= 1'b0;
      deD2  <= 1'b0;
      vsD1  <= 1'b0;
      vsD2  <= 1'b0;
    end else begin
      pixD1 <= iPixelData;
      deD1  <= iDE;
      deD2  <= deD1;
      vsD1  <= iVS;
      vsD2  <= vsD1;
    end
  end

  // The last pixel of a line has been folded into the lanes by the time
  // lineEnd is seen, so a band can be published straight from accBus.
  assign lineEnd    = deD2 & ~deD1;
  assign bandEnd    = lineEnd & (lineCnt == LAST_LINE);
  assign frameStart = vsD1 & ~vsD2;
  assign publish    = bandEnd & ~frameStart;
  assign accClr     = frameStart | bandEnd;

  always_ff @(posedge iODCK or negedge iRst_n) begin
    if (!iRst_n) begin
      lineCnt <= '0;
      bandCnt <= '0;
    end else if (frameStart) begin
      lineCnt <= '0;
      bandCnt <= '0;
    end else if (lineEnd) begin
      if (bandEnd) begin
        lineCnt <= '0;
        bandCnt <= (bandCnt == LAST_BAND) ? '0 : bandCnt + BAND_IDX_W'(1);
      end else begin
        lineCnt <= lineCnt + LINE_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iODCK or negedge iRst_n) begin
    if (!iRst_n) begin
      oZoneMax   <= '0;
      oZoneValid <= 1'b0;
      oBandIdx   <= '0;
      oFrameDone <= 1'b0;
    end else begin
      oZoneValid <= publish;
      oFrameDone <= publish & (bandCnt == LAST_BAND);
      if (publish) begin
        oZoneMax <= accBus;
        oBandIdx <= bandCnt;
      end
    end
  end

  for (genvar z = 0; z < ZONES; z++) begin : gLane
    zone_lane_max uLane (
      .iODCK  (iODCK),
      .iRst_n (iRst_n),
      .iClr   (accClr),
      .iEn    (deD1),
      .iPix   (pixD1[z*LANE_W +: LANE_W]),
      .oMax   (accBus[z*LANE_W +: LANE_W])
    );
  end

endmodule
